// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared types, rule constants and cell rule for the Life sequencer
package conway_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3,
    WR,
    SH,
    FLIP,
    DONE
  } state_t;

  localparam int BIRTH_N   = 3;
  localparam int SURVIVE_N = 2;

  // Next state of one cell given its current state and live-neighbour count (0..8).
  function automatic logic cell_next(input logic c, input logic [3:0] n);
    return (n == 4'(BIRTH_N)) || (c && (n == 4'(SURVIVE_N)));
  endfunction

endpackage

// File: rtl/conway_row_rule.sv
// rtl/conway_row_rule.sv - combinational Life rule across one row with horizontal wrap
//
// Ports:
//   up   in  GRID_W  row above the row being computed
//   mid  in  GRID_W  row being computed (current generation)
//   dn   in  GRID_W  row below the row being computed
//   nxt  out GRID_W  next generation of mid
// Column i is bit i; column 0's west neighbour is column GRID_W-1.
module conway_row_rule
  import conway_pkg::*;
#(
  parameter int GRID_W = 32
) (
  input  logic [GRID_W-1:0] up,
  input  logic [GRID_W-1:0] mid,
  input  logic [GRID_W-1:0] dn,
  output logic [GRID_W-1:0] nxt
);

  // Rotated copies so that x_w[i] is the west neighbour and x_e[i] the east neighbour of column i.
  logic [GRID_W-1:0] up_w, up_e, mid_w, mid_e, dn_w, dn_e;

  assign up_w  = {up[GRID_W-2:0], up[GRID_W-1]};
  assign up_e  = {up[0], up[GRID_W-1:1]};
  assign mid_w = {mid[GRID_W-2:0], mid[GRID_W-1]};
  assign mid_e = {mid[0], mid[GRID_W-1:1]};
  assign dn_w  = {dn[GRID_W-2:0], dn[GRID_W-1]};
  assign dn_e  = {dn[0], dn[GRID_W-1:1]};

  for (genvar i = 0; i < GRID_W; i++) begin : g_cell
    logic [3:0] n;
    assign n = 4'(up_w[i]) + 4'(up[i]) + 4'(up_e[i])
             + 4'(mid_w[i]) + 4'(mid_e[i])
             + 4'(dn_w[i]) + 4'(dn[i]) + 4'(dn_e[i]);
    assign nxt[i] = cell_next(mid[i], n);
  end

endmodule

// File: rtl/conway_gen_sequencer.sv
// rtl/conway_gen_sequencer.sv - runs Game-of-Life generations over a ping-pong row memory
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start         pulse, accepted only when idle; samples num_gens
//   stop          request to halt after the generation in progress
//   num_gens      generations to run
//   busy, done    run in progress / one-cycle end-of-run pulse
//   cur_bank      bank holding the complete current generation
//   gen_count     generations completed since reset (wraps)
//   mem_rd_*      row read port {bank,row}; data returns the cycle after mem_rd_en
//   mem_wr_*      row write port {bank,row}
// Rows are read from bank cur_bank and written to bank ~cur_bank; cur_bank only
// flips once a whole generation has been written.
module conway_gen_sequencer
  import conway_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int ROW_AW = $clog2(GRID_H),
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [GEN_W-1:0]  num_gens,
  output logic              busy,
  output logic              done,
  output logic              cur_bank,
  output logic [GEN_W-1:0]  gen_count,
  output logic              mem_rd_en,
  output logic [ROW_AW:0]   mem_rd_addr,
  input  logic [GRID_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ROW_AW:0]   mem_wr_addr,
  output logic [GRID_W-1:0] mem_wr_data
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(GRID_H - 1);
  localparam logic [ROW_AW-1:0] WRAP_ROW = ROW_AW'(GRID_H - 2);

  state_t            state, state_next;
  logic [ROW_AW-1:0] row;
  logic [ROW_AW-1:0] row_ahead;
  logic [GEN_W-1:0]  rem;
  logic [GRID_W-1:0] win_up, win_mid, win_dn;
  logic [GRID_W-1:0] next_row;
  logic              stop_pending;

  conway_row_rule #(.GRID_W(GRID_W)) u_rule (
    .up  (win_up),
    .mid (win_mid),
    .dn  (win_dn),
    .nxt (next_row)
  );

  // Row fetched while writing row r is (r+2) mod H; only r==H-2 wraps (r==H-1 issues no read).
  assign row_ahead = (row == WRAP_ROW) ? '0 : row + ROW_AW'(2);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_bank     <= 1'b0;
      gen_count    <= '0;
      rem          <= '0;
      row          <= '0;
      win_up       <= '0;
      win_mid      <= '0;
      win_dn       <= '0;
      stop_pending <= 1'b0;
    end else begin
      state <= state_next;

      if (state == DONE)
        stop_pending <= 1'b0;
      else if (state != IDLE && stop)
        stop_pending <= 1'b1;

      case (state)
        IDLE: if (start) rem <= num_gens;
        P1:   win_up  <= mem_rd_data;
        P2:   win_mid <= mem_rd_data;
        P3: begin
          win_dn <= mem_rd_data;
          row    <= '0;
        end
        SH: begin
          win_up  <= win_mid;
          win_mid <= win_dn;
          if (row != LAST_ROW) begin
            win_dn <= mem_rd_data;
            row    <= row + ROW_AW'(1);
          end
        end
        FLIP: begin
          cur_bank  <= ~cur_bank;
          gen_count <= gen_count + GEN_W'(1);
          rem       <= rem - GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;

    case (state)
      IDLE: begin
        if (start)
          state_next = (num_gens == '0) ? DONE : P0;
      end
      P0: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = {cur_bank, LAST_ROW};
        state_next  = P1;
      end
      P1: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = {cur_bank, ROW_AW'(0)};
        state_next  = P2;
      end
      P2: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = {cur_bank, ROW_AW'(1)};
        state_next  = P3;
      end
      P3: state_next = WR;
      WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = {~cur_bank, row};
        mem_wr_data = next_row;
        if (row != LAST_ROW) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = {cur_bank, row_ahead};
        end
        state_next = SH;
      end
      SH: state_next = (row == LAST_ROW) ? FLIP : WR;
      // rem still holds the pre-decrement value here, so 1 means this was the last generation.
      FLIP: state_next = ((rem == GEN_W'(1)) || stop_pending || stop) ? DONE : P0;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conway_gen_sequencer.sv
// tb/tb_conway_gen_sequencer.sv - directed self-checking bench for conway_gen_sequencer
module tb_conway_gen_sequencer;

  localparam logic [63:0] BLOCK      = 64'h00000018_18000000;
  localparam logic [63:0] GLIDER     = 64'h01000000_00008302;
  localparam logic [63:0] GLIDER_EXP = 64'h00000000_00070402;
  localparam logic [24:0] BLINK      = 25'h0003800;
  localparam logic [24:0] BLINK_EXP  = 25'h0021080;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8x8 instance
  logic        start8 = 0, stop8 = 0, busy8, done8, bank8, rd8, wr8;
  logic [15:0] num8 = 0, gc8;
  logic [3:0]  ra8, wa8, lda8 = 0;
  logic [7:0]  rdat8, wd8, ldd8 = 0;
  logic        ld8 = 0;
  logic [7:0]  m8 [0:15];
  int          ev8;

  // 5x5 instance
  logic        start5 = 0, stop5 = 0, busy5, done5, bank5, rd5, wr5;
  logic [15:0] num5 = 0, gc5;
  logic [3:0]  ra5, wa5, lda5 = 0;
  logic [4:0]  rdat5, wd5, ldd5 = 0;
  logic        ld5 = 0;
  logic [4:0]  m5 [0:15];

  conway_gen_sequencer #(.GRID_W(8), .GRID_H(8), .GEN_W(16)) u8 (
    .clk(clk), .rst(rst), .start(start8), .stop(stop8), .num_gens(num8),
    .busy(busy8), .done(done8), .cur_bank(bank8), .gen_count(gc8),
    .mem_rd_en(rd8), .mem_rd_addr(ra8), .mem_rd_data(rdat8),
    .mem_wr_en(wr8), .mem_wr_addr(wa8), .mem_wr_data(wd8)
  );

  conway_gen_sequencer #(.GRID_W(5), .GRID_H(5), .GEN_W(16)) u5 (
    .clk(clk), .rst(rst), .start(start5), .stop(stop5), .num_gens(num5),
    .busy(busy5), .done(done5), .cur_bank(bank5), .gen_count(gc5),
    .mem_rd_en(rd5), .mem_rd_addr(ra5), .mem_rd_data(rdat5),
    .mem_wr_en(wr5), .mem_wr_addr(wa5), .mem_wr_data(wd5)
  );

  always @(posedge clk) begin
    if (ld8) m8[lda8] <= ldd8;
    else if (wr8) m8[wa8] <= wd8;
    if (rd8) rdat8 <= m8[ra8];
  end

  always @(posedge clk) begin
    if (ld5) m5[lda5] <= ldd5;
    else if (wr5) m5[wa5] <= wd5;
    if (rd5) rdat5 <= m5[ra5];
  end

  always @(posedge clk) begin
    if (rst) ev8 <= 0;
    else if (rd8 || wr8) ev8 <= ev8 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] grid8(input logic b);
    logic [63:0] g;
    for (int r = 0; r < 8; r++) g[r*8 +: 8] = m8[{b, 3'(r)}];
    return g;
  endfunction

  function automatic logic [24:0] grid5(input logic b);
    logic [24:0] g;
    for (int r = 0; r < 5; r++) g[r*5 +: 5] = m5[{b, 3'(r)}];
    return g;
  endfunction

  task automatic load8(input logic b, input logic [63:0] g);
    for (int r = 0; r < 8; r++) begin
      ld8 = 1'b1; lda8 = {b, 3'(r)}; ldd8 = g[r*8 +: 8];
      @(negedge clk);
    end
    ld8 = 1'b0;
  endtask

  // Pulses start, waits (bounded) for done, checks latency and the return to idle.
  task automatic run8(input logic [15:0] ng, input int exp_k, input string tag);
    int k;
    num8 = ng; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; stop8 = 1'b0; k = 1;
    while (done8 !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_cycles"}, 64'(k), 64'(exp_k));
    chk({tag, "_busy_at_done"}, 64'(busy8), 64'd1);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({busy8, done8}), 64'd0);
  endtask

  initial begin
    int k;
    int e0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_u8", 64'({busy8, done8, rd8, wr8, bank8, gc8}), 64'd0);
    chk("reset_u5", 64'({busy5, done5, rd5, wr5, bank5, gc5}), 64'd0);

    // Blinker on 5x5: one generation, 4 + 10 + 1 + 1 cycles to done.
    for (int r = 0; r < 5; r++) begin
      ld5 = 1'b1; lda5 = {1'b0, 3'(r)}; ldd5 = BLINK[r*5 +: 5];
      @(negedge clk);
    end
    ld5 = 1'b0;
    num5 = 16'd1; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0; k = 1;
    while (done5 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("blink_cycles", 64'(k), 64'd16);
    chk("blink_grid", 64'(grid5(1'b1)), 64'(BLINK_EXP));
    chk("blink_bank", 64'(bank5), 64'd1);
    chk("blink_gc", 64'(gc5), 64'd1);
    @(negedge clk);
    chk("blink_idle", 64'({busy5, done5}), 64'd0);

    // Still-life block over 4 generations on 8x8: 4 * 21 + 1 cycles.
    load8(1'b0, BLOCK);
    run8(16'd4, 85, "block");
    chk("block_bank0", grid8(1'b0), BLOCK);
    chk("block_bank1", grid8(1'b1), BLOCK);
    chk("block_gc", 64'(gc8), 64'd4);
    chk("block_cur_bank", 64'(bank8), 64'd0);

    // Glider straddling both wrap seams moves by (+1,+1) in 4 generations.
    load8(1'b0, GLIDER);
    run8(16'd4, 85, "glider");
    chk("glider_grid", grid8(1'b0), GLIDER_EXP);
    chk("glider_gc", 64'(gc8), 64'd8);

    // num_gens = 0: done on the cycle after start, no memory traffic.
    e0 = ev8;
    run8(16'd0, 1, "zero");
    chk("zero_no_mem", 64'(ev8), 64'(e0));
    chk("zero_gc", 64'(gc8), 64'd8);

    // stop while idle and together with start is ignored: both generations run.
    load8(1'b0, BLOCK);
    stop8 = 1'b1;
    @(negedge clk);
    run8(16'd2, 43, "stop_idle");
    chk("stop_idle_gc", 64'(gc8), 64'd10);

    // Asynchronous reset during the first row write of a run.
    num8 = 16'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_wr", 64'(wr8), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst", 64'({busy8, done8, rd8, wr8, bank8, gc8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // num_gens = 5 with stop in generation 2 and a repeated start while busy.
    load8(1'b0, BLOCK);
    num8 = 16'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (9) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (19) @(negedge clk);
    stop8 = 1'b1;
    @(negedge clk);
    stop8 = 1'b0;
    repeat (11) @(negedge clk);
    chk("stop_flip", 64'({busy8, done8}), 64'b10);
    chk("stop_flip_gc", 64'(gc8), 64'd1);
    @(negedge clk);
    chk("stop_done", 64'(done8), 64'd1);
    chk("stop_gc", 64'(gc8), 64'd2);
    chk("stop_bank", 64'(bank8), 64'd0);
    chk("stop_grid", grid8(1'b0), BLOCK);
    @(negedge clk);
    chk("stop_idle", 64'({busy8, done8}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
